stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Consumer end of the push-button path: takes the debounced one-pulse button events and a periodic tick from the clock generator.
- Runs a start/stop/lap/clear state machine and a 4-digit BCD MM:SS counter.
- Drives the digit values to the SSD scan logic, plus status flags.
- Sits between the debounce/one-pulse front end and the display driver, in the single `clk` domain.

Parameters:
- TICK_DIV, 100, number of `tick` pulses per one-second increment; legal range 1..1023. Prescaler width is 10 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  one-`clk`-wide enable pulse at the count rate (e.g. 100 Hz).
- ss_in  input  1  start/stop button event, synchronous to `clk`.
- lap_in  input  1  lap/clear button event, synchronous to `clk`.
- digit3  output  4  minutes tens, BCD 0..5.
- digit2  output  4  minutes ones, BCD 0..9.
- digit1  output  4  seconds tens, BCD 0..5.
- digit0  output  4  seconds ones, BCD 0..9.
- running  output  1  high in RUN or LAP_RUN.
- lap_active  output  1  high in LAP_RUN; displayed value is frozen.
- wrap  output  1  one-cycle pulse on the 59:59 -> 00:00 rollover.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - state = IDLE; live count = 00:00; lap register = 00:00; prescaler = 0.
  - All outputs 0; edge-detect registers = 0.
- Input qualification:
  - ss_ev = `ss_in` & ~ss_d, where ss_d is `ss_in` registered. `lap_ev` is formed the same way.
  - A level held high for N cycles therefore yields exactly one event.
- States and transitions (evaluated on ss_ev/lap_ev in the current state):
  - IDLE: ss_ev -> RUN; lap_ev ignored.
  - RUN: ss_ev -> PAUSE; lap_ev -> LAP_RUN and capture the live count into the lap register on the same edge.
  - LAP_RUN: ss_ev -> PAUSE (freeze released); lap_ev -> RUN (freeze released).
  - PAUSE: ss_ev -> RUN; lap_ev -> IDLE, clearing the live count, lap register and prescaler to 0.
- Simultaneous ss_ev and lap_ev: ss_ev wins and lap_ev is dropped.
- Counting:
  - Enabled only when the current (pre-edge) state is RUN or LAP_RUN.
  - On a `tick` with counting enabled: if prescaler == TICK_DIV-1, prescaler -> 0 and the count increments by one second; otherwise prescaler++.
  - Prescaler holds in PAUSE and is not reset by pause/resume.
- BCD increment:
  - s0 9 -> 0 carries into s1.
  - s1 5 -> 0 carries into m0.
  - m0 9 -> 0 carries into m1.
  - m1 5 -> 0 means 59:59 -> 00:00 rollover; `wrap` = 1 for exactly one cycle, on the edge after the increment.
- Latency: the count is visible on `digit*` one edge after the qualifying `tick`. State flags change on the edge that consumes the event; the event edge is one cycle after the `ss_in`/`lap_in` rising edge.
- Display mux: `digit*` = lap register when lap_active = 1, else the live count. All outputs are driven from registers (no combinational path from inputs).
- Boundary cases:
  - `tick` in the same cycle as ss_ev in RUN: the tick is counted (pre-edge state RUN), then PAUSE.
  - `tick` in the same cycle as clear: clear wins and the count = 00:00.
  - `tick` in the same cycle as ss_ev in IDLE/PAUSE: not counted.
  - lap_ev in RUN in the same cycle as an increment: the lap register captures the pre-increment value.
- Reset mid-operation: immediate return to the reset state regardless of state; no pending event survives.

Optional Feature:
- Macro: STOPWATCH_SATURATE_EN.
- Defined:
  - At 59:59 a further increment does not roll over: the count holds 59:59 and state is forced to PAUSE on that edge.
  - `wrap` pulses one cycle to signal done. In this saturated PAUSE, ss_ev -> RUN is ignored until a clear (lap_ev -> IDLE).
- Undefined: modular wrap as above; `wrap` pulses and counting continues from 00:00.

Test Plan:
- Reset then TICK_DIV=1; ss_in pulse; 75 ticks -> digits 01:15, running = 1, wrap never asserted.
- `ss_in` held high 20 cycles in IDLE -> exactly one transition to RUN; running = 1 from 2 cycles after the rising edge.
- RUN at 00:42, lap_in pulse, 10 more ticks -> display holds 00:42 with lap_active = 1; second lap_in -> display 00:52, lap_active = 0.
- RUN at 00:30, ss_in and lap_in in the same cycle -> PAUSE, count 00:30, lap ignored; then lap_in -> IDLE, 00:00.
- Preload by 3599 ticks to 59:59, one more tick -> 00:00 and a single-cycle wrap. With STOPWATCH_SATURATE_EN: holds 59:59, running = 0, ss_in ignored until clear.
- TICK_DIV=100, RUN, 150 ticks, reset = 0 asserted mid-run -> all outputs 0 asynchronously, state IDLE; after release, ss_in -> count restarts from prescaler 0.

Source files
------------

// File: rtl/stopwatch_core.sv
// Start/stop/lap/clear stopwatch with a 4-digit BCD MM:SS counter.
// Define STOPWATCH_SATURATE_EN to stop at 59:59 instead of rolling over to 00:00.
module stopwatch_core #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ss_in,
    input  logic       lap_in,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       running,
    output logic       lap_active,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        LAP_RUN = 2'd2,
        PAUSE   = 2'd3
    } state_t;

    localparam logic [9:0]  PRESC_MAX = 10'(TICK_DIV - 1);
    localparam logic [15:0] COUNT_MAX = 16'h5959;

    state_t      state, state_nx;
    logic [15:0] count, count_nx;
    logic [15:0] lap_reg, lap_nx;
    logic [9:0]  presc, presc_nx;
    logic        wrap_nx;
    logic        ss_d, lap_d;
    logic        ss_ev, lap_ev, lap_take;
    logic        tick_en, sec_inc, at_max;
    logic        resume_ok;
    logic [15:0] count_inc;
    logic [15:0] disp_nx;

`ifdef STOPWATCH_SATURATE_EN
    logic saturated, sat_nx;
    assign resume_ok = ~saturated;
`else
    assign resume_ok = 1'b1;
`endif

    // Digits are {m1, m0, s1, s0}; each carries only when it reaches its top value.
    function automatic logic [15:0] bcd_inc(input logic [15:0] c);
        logic [3:0] d3, d2, d1, d0;
        {d3, d2, d1, d0} = c;
        if (d0 != 4'd9) begin
            d0 = d0 + 4'd1;
        end else begin
            d0 = 4'd0;
            if (d1 != 4'd5) begin
                d1 = d1 + 4'd1;
            end else begin
                d1 = 4'd0;
                if (d2 != 4'd9) begin
                    d2 = d2 + 4'd1;
                end else begin
                    d2 = 4'd0;
                    d3 = (d3 == 4'd5) ? 4'd0 : d3 + 4'd1;
                end
            end
        end
        return {d3, d2, d1, d0};
    endfunction

    assign ss_ev     = ss_in & ~ss_d;
    assign lap_ev    = lap_in & ~lap_d;
    assign lap_take  = lap_ev & ~ss_ev;
    assign tick_en   = tick & ((state == RUN) || (state == LAP_RUN));
    assign sec_inc   = tick_en && (presc == PRESC_MAX);
    assign at_max    = (count == COUNT_MAX);
    assign count_inc = bcd_inc(count);

    // Counting uses the pre-edge state; events then pick the next state, and a clear overrides the count.
    always_comb begin
        state_nx = state;
        count_nx = count;
        lap_nx   = lap_reg;
        presc_nx = presc;
        wrap_nx  = 1'b0;
`ifdef STOPWATCH_SATURATE_EN
        sat_nx   = saturated;
`endif

        if (tick_en) begin
            presc_nx = sec_inc ? 10'd0 : presc + 10'd1;
        end

        if (sec_inc) begin
            wrap_nx = at_max;
`ifdef STOPWATCH_SATURATE_EN
            if (at_max) begin
                sat_nx = 1'b1;
            end else begin
                count_nx = count_inc;
            end
`else
            count_nx = count_inc;
`endif
        end

        case (state)
            IDLE: begin
                if (ss_ev) state_nx = RUN;
            end
            RUN: begin
                if (ss_ev) begin
                    state_nx = PAUSE;
                end else if (lap_take) begin
                    state_nx = LAP_RUN;
                    lap_nx   = count;
                end
            end
            LAP_RUN: begin
                if (ss_ev) begin
                    state_nx = PAUSE;
                end else if (lap_take) begin
                    state_nx = RUN;
                end
            end
            PAUSE: begin
                if (ss_ev) begin
                    if (resume_ok) state_nx = RUN;
                end else if (lap_take) begin
                    state_nx = IDLE;
                    count_nx = 16'h0000;
                    lap_nx   = 16'h0000;
                    presc_nx = 10'd0;
`ifdef STOPWATCH_SATURATE_EN
                    sat_nx   = 1'b0;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase

`ifdef STOPWATCH_SATURATE_EN
        if (sec_inc && at_max) state_nx = PAUSE;
`endif

        disp_nx = (state_nx == LAP_RUN) ? lap_nx : count_nx;
    end

    // All outputs are registered from the next-state values so they change with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= 16'h0000;
            lap_reg    <= 16'h0000;
            presc      <= 10'd0;
            ss_d       <= 1'b0;
            lap_d      <= 1'b0;
            wrap       <= 1'b0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            {digit3, digit2, digit1, digit0} <= 16'h0000;
`ifdef STOPWATCH_SATURATE_EN
            saturated  <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            lap_reg    <= lap_nx;
            presc      <= presc_nx;
            ss_d       <= ss_in;
            lap_d      <= lap_in;
            wrap       <= wrap_nx;
            running    <= (state_nx == RUN) || (state_nx == LAP_RUN);
            lap_active <= (state_nx == LAP_RUN);
            {digit3, digit2, digit1, digit0} <= disp_nx;
`ifdef STOPWATCH_SATURATE_EN
            saturated  <= sat_nx;
`endif
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: one instance with TICK_DIV=1 and one with TICK_DIV=100.
// Both instances share the same stimulus.
module tb_stopwatch_core;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic ss_in = 1'b0;
    logic lap_in = 1'b0;

    logic [3:0] a_d3, a_d2, a_d1, a_d0, b_d3, b_d2, b_d1, b_d0;
    logic a_running, a_lap, a_wrap, b_running, b_lap, b_wrap;
    logic [15:0] a_disp, b_disp;

    int checks = 0;
    int failures = 0;
    int wrap_cnt_a = 0;

    assign a_disp = {a_d3, a_d2, a_d1, a_d0};
    assign b_disp = {b_d3, b_d2, b_d1, b_d0};

    stopwatch_core #(.TICK_DIV(1)) dut_a (
        .clk(clk), .reset(reset), .tick(tick), .ss_in(ss_in), .lap_in(lap_in),
        .digit3(a_d3), .digit2(a_d2), .digit1(a_d1), .digit0(a_d0),
        .running(a_running), .lap_active(a_lap), .wrap(a_wrap)
    );

    stopwatch_core #(.TICK_DIV(100)) dut_b (
        .clk(clk), .reset(reset), .tick(tick), .ss_in(ss_in), .lap_in(lap_in),
        .digit3(b_d3), .digit2(b_d2), .digit1(b_d1), .digit0(b_d0),
        .running(b_running), .lap_active(b_lap), .wrap(b_wrap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && a_wrap) wrap_cnt_a++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Holds the given levels for n clock edges, then drops them for one idle edge.
    task automatic applyStimulus(input logic s, input logic l, input logic t, input int n);
        ss_in = s;
        lap_in = l;
        tick = t;
        repeat (n) @(negedge clk);
        ss_in = 1'b0;
        lap_in = 1'b0;
        tick = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_a", {a_disp, a_running, a_lap, a_wrap}, 32'h0);
        checkOutput("reset_b", {b_disp, b_running, b_lap, b_wrap}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Start and count 75 seconds.
        applyStimulus(1, 0, 0, 1);
        checkOutput("start_running", a_running, 1);
        applyStimulus(0, 0, 1, 75);
        checkOutput("count_0115", a_disp, 16'h0115);
        checkOutput("count_running", a_running, 1);
        checkOutput("no_wrap_yet", wrap_cnt_a, 0);

        // Pause, clear, then hold start/stop high for 20 cycles.
        applyStimulus(1, 0, 0, 1);
        checkOutput("pause_running", a_running, 0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("clear_digits", a_disp, 16'h0000);
        ss_in = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("held_run_2cyc", a_running, 1);
        repeat (18) @(negedge clk);
        ss_in = 1'b0;
        @(negedge clk);
        checkOutput("held_one_event", a_running, 1);

        // Lap freeze at 00:42 while counting continues.
        applyStimulus(0, 0, 1, 42);
        checkOutput("count_0042", a_disp, 16'h0042);
        applyStimulus(0, 1, 0, 1);
        checkOutput("lap_active_on", a_lap, 1);
        applyStimulus(0, 0, 1, 10);
        checkOutput("lap_frozen", a_disp, 16'h0042);
        applyStimulus(0, 1, 0, 1);
        checkOutput("lap_active_off", a_lap, 0);
        checkOutput("lap_release", a_disp, 16'h0052);

        // Lap event coinciding with an increment captures the pre-increment value.
        applyStimulus(0, 1, 1, 1);
        checkOutput("lap_pre_inc", a_disp, 16'h0052);
        applyStimulus(0, 1, 0, 1);
        checkOutput("lap_post_inc", a_disp, 16'h0053);

        // Reach 00:30, then simultaneous start/stop and lap.
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 1, 30);
        checkOutput("count_0030", a_disp, 16'h0030);
        applyStimulus(1, 1, 0, 1);
        checkOutput("simul_paused", {a_running, a_lap}, 0);
        checkOutput("simul_digits", a_disp, 16'h0030);
        applyStimulus(0, 1, 0, 1);
        checkOutput("clear_to_idle", {a_disp, a_running}, 0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("idle_lap_ignored", {a_disp, a_running, a_lap}, 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("idle_start", a_running, 1);

        // Tick with start/stop: counted from RUN, not counted from PAUSE.
        applyStimulus(1, 0, 1, 1);
        checkOutput("tick_ss_run", {a_disp, a_running}, {16'h0001, 1'b0});
        applyStimulus(1, 0, 1, 1);
        checkOutput("tick_ss_pause", {a_disp, a_running}, {16'h0001, 1'b1});

        // Preload to 59:59, then one more second.
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 1, 3599);
        checkOutput("count_5959", a_disp, 16'h5959);
        checkOutput("no_wrap_5959", wrap_cnt_a, 0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
`ifdef STOPWATCH_SATURATE_EN
        checkOutput("sat_hold", {a_disp, a_running}, {16'h5959, 1'b0});
        checkOutput("sat_wrap_pulse", a_wrap, 1);
        @(negedge clk);
        checkOutput("sat_wrap_end", a_wrap, 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("sat_ss_ignored", a_running, 0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("sat_clear", a_disp, 16'h0000);
        applyStimulus(1, 0, 0, 1);
        checkOutput("sat_restart", a_running, 1);
`else
        checkOutput("rollover", a_disp, 16'h0000);
        checkOutput("wrap_pulse", a_wrap, 1);
        @(negedge clk);
        checkOutput("wrap_end", a_wrap, 0);
        checkOutput("still_running", a_running, 1);
`endif
        checkOutput("wrap_count", wrap_cnt_a, 1);

        // TICK_DIV=100: 150 ticks, asynchronous reset mid-run, prescaler restarts.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 1, 150);
        checkOutput("b_count_0001", {b_disp, b_running}, {16'h0001, 1'b1});
        #2 reset = 1'b0;
        #1 checkOutput("b_async_reset", {b_disp, b_running, b_lap, b_wrap}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(1, 0, 0, 1);
        checkOutput("b_restart", b_running, 1);
        applyStimulus(0, 0, 1, 99);
        checkOutput("b_presc_99", b_disp, 16'h0000);
        applyStimulus(0, 0, 1, 1);
        checkOutput("b_presc_100", b_disp, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
